// File: rtl/capacitive_sensor_scanner.sv
`default_nettype none
// ============================================================================
// Module      : capacitive_sensor_scanner
// Description : Charges N RC sensor pads from one shared drive pin and times
//               each pad's discharge. Publishes a coherent snapshot of counts
//               with a valid strobe, plus charge and discharge fault flags.
//               Optional touch detection is enabled by CAP_SENSOR_TOUCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module capacitive_sensor_scanner #(
  parameter int NUM_SENSORS       = 9,
  parameter int COUNT_WIDTH       = 32,
  parameter int PERIOD_CYCLES     = 100000,
  parameter int CHARGE_CYCLES     = 20000,
  parameter int CHARGE_TIMEOUT    = 40000,
  parameter int DISCHARGE_TIMEOUT = 30000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_SENSORS-1:0]             sensors_in,
  output logic                               sensors_out,
  output logic [NUM_SENSORS*COUNT_WIDTH-1:0] readings,
  output logic                               readings_valid,
  output logic [NUM_SENSORS-1:0]             discharge_timeout,
  output logic                               charge_fault
`ifdef CAP_SENSOR_TOUCH_EN
  ,
  input  logic [COUNT_WIDTH-1:0]             touch_threshold,
  output logic [NUM_SENSORS-1:0]             touched
`endif
);

  localparam int c_PERIOD_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int c_CHARGE_W  = $clog2(CHARGE_CYCLES + 1);
  localparam int c_TO_MAX    = (CHARGE_TIMEOUT > DISCHARGE_TIMEOUT) ? CHARGE_TIMEOUT
                                                                     : DISCHARGE_TIMEOUT;
  localparam int c_TIMEOUT_W = $clog2(c_TO_MAX + 1);

  localparam logic [c_PERIOD_W-1:0]  c_PERIOD_LAST = c_PERIOD_W'(PERIOD_CYCLES - 1);
  localparam logic [c_CHARGE_W-1:0]  c_CHARGE_LAST = c_CHARGE_W'(CHARGE_CYCLES - 1);
  localparam logic [c_TIMEOUT_W-1:0] c_CHG_TO_LAST = c_TIMEOUT_W'(CHARGE_TIMEOUT - 1);
  localparam logic [c_TIMEOUT_W-1:0] c_DIS_TO_LAST = c_TIMEOUT_W'(DISCHARGE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CHARGE    = 2'd1,
    ST_DISCHARGE = 2'd2,
    ST_LATCH     = 2'd3
  } state_t;

  state_t                   r_state;
  logic [NUM_SENSORS-1:0]   r_sync1;
  logic [NUM_SENSORS-1:0]   r_sync2;
  logic [c_PERIOD_W-1:0]    r_period_cnt;
  logic [c_CHARGE_W-1:0]    r_charge_cnt;
  logic [c_TIMEOUT_W-1:0]   r_timeout_cnt;
  logic [COUNT_WIDTH-1:0]   r_cnt [NUM_SENSORS];
  logic [NUM_SENSORS-1:0]   r_stopped;
  logic [NUM_SENSORS-1:0]   r_flags;

  logic                     w_all_high;
  logic [NUM_SENSORS-1:0]   w_stop_next;
  logic [COUNT_WIDTH-1:0]   w_cnt_inc [NUM_SENSORS];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sensors_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_period_cnt <= '0;
    end else if (r_period_cnt == c_PERIOD_LAST) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + 1'b1;
    end
  end

  assign w_all_high  = &r_sync2;
  // A channel stops on its first low sample and stays stopped for the scan.
  assign w_stop_next = r_stopped | ~r_sync2;

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_chan
    assign w_cnt_inc[g] = (r_cnt[g] == '1) ? r_cnt[g] : r_cnt[g] + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state           <= ST_IDLE;
      sensors_out       <= 1'b0;
      r_charge_cnt      <= '0;
      r_timeout_cnt     <= '0;
      r_stopped         <= '0;
      r_flags           <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        r_cnt[i] <= '0;
      end
      readings          <= '0;
      readings_valid    <= 1'b0;
      discharge_timeout <= '0;
      charge_fault      <= 1'b0;
    end else begin
      readings_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_period_cnt == '0) begin
            r_state       <= ST_CHARGE;
            sensors_out   <= 1'b1;
            r_charge_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_stopped     <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
              r_cnt[i] <= '0;
            end
          end
        end

        ST_CHARGE: begin
          r_timeout_cnt <= r_timeout_cnt + 1'b1;
          r_charge_cnt  <= w_all_high ? r_charge_cnt + 1'b1 : '0;
          // Reaching the charged condition wins over a coincident timeout.
          if (w_all_high && (r_charge_cnt == c_CHARGE_LAST)) begin
            r_state       <= ST_DISCHARGE;
            sensors_out   <= 1'b0;
            r_timeout_cnt <= '0;
          end else if (r_timeout_cnt == c_CHG_TO_LAST) begin
            r_state      <= ST_IDLE;
            sensors_out  <= 1'b0;
            charge_fault <= 1'b1;
          end
        end

        ST_DISCHARGE: begin
          r_timeout_cnt <= r_timeout_cnt + 1'b1;
          r_stopped     <= w_stop_next;
          for (int i = 0; i < NUM_SENSORS; i++) begin
            if (!w_stop_next[i]) begin
              r_cnt[i] <= w_cnt_inc[i];
            end
          end
          if ((&w_stop_next) || (r_timeout_cnt == c_DIS_TO_LAST)) begin
            r_state <= ST_LATCH;
            r_flags <= ~w_stop_next;
          end
        end

        ST_LATCH: begin
          for (int i = 0; i < NUM_SENSORS; i++) begin
            readings[i*COUNT_WIDTH +: COUNT_WIDTH] <= r_cnt[i];
          end
          discharge_timeout <= r_flags;
          charge_fault      <= 1'b0;
          readings_valid    <= 1'b1;
          r_state           <= ST_IDLE;
        end

        default: begin
          r_state     <= ST_IDLE;
          sensors_out <= 1'b0;
        end
      endcase
    end
  end

`ifdef CAP_SENSOR_TOUCH_EN
  logic [COUNT_WIDTH-1:0] r_baseline [NUM_SENSORS];
  logic                   r_base_valid;
  logic [COUNT_WIDTH-1:0] w_touch_limit [NUM_SENSORS];

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_touch
    logic [COUNT_WIDTH:0] w_sum;
    assign w_sum            = {1'b0, r_baseline[g]} + {1'b0, touch_threshold};
    assign w_touch_limit[g] = w_sum[COUNT_WIDTH] ? '1 : w_sum[COUNT_WIDTH-1:0];
  end

  // Evaluated on the LATCH edge so touched moves together with readings.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_base_valid <= 1'b0;
      touched      <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        r_baseline[i] <= '0;
      end
    end else if (r_state == ST_LATCH) begin
      if (!r_base_valid) begin
        r_base_valid <= 1'b1;
        for (int i = 0; i < NUM_SENSORS; i++) begin
          r_baseline[i] <= r_cnt[i];
        end
      end else begin
        for (int i = 0; i < NUM_SENSORS; i++) begin
          touched[i] <= (r_cnt[i] > w_touch_limit[i]);
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_capacitive_sensor_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_capacitive_sensor_scanner
// Description : Directed bench with a cycle-level pad model. Pads follow the
//               drive on the cycle it is seen; fall delays are expressed as
//               the number of high samples at the synchroniser output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capacitive_sensor_scanner;

  localparam int N  = 3;
  localparam int CW = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      sensors_in = '0;
  logic              sensors_out;
  logic [N*CW-1:0]   readings;
  logic              readings_valid;
  logic [N-1:0]      discharge_timeout;
  logic              charge_fault;
`ifdef CAP_SENSOR_TOUCH_EN
  logic [CW-1:0]     touch_threshold = 32'd2;
  logic [N-1:0]      touched;
`endif

  capacitive_sensor_scanner #(
    .NUM_SENSORS       (N),
    .COUNT_WIDTH       (CW),
    .PERIOD_CYCLES     (64),
    .CHARGE_CYCLES     (4),
    .CHARGE_TIMEOUT    (10),
    .DISCHARGE_TIMEOUT (20)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .sensors_in        (sensors_in),
    .sensors_out       (sensors_out),
    .readings          (readings),
    .readings_valid    (readings_valid),
    .discharge_timeout (discharge_timeout),
    .charge_fault      (charge_fault)
`ifdef CAP_SENSOR_TOUCH_EN
    ,
    .touch_threshold   (touch_threshold),
    .touched           (touched)
`endif
  );

  always #5 clock = ~clock;

  int           errors    = 0;
  int           checks    = 0;
  int           hi_cnt    = 0;
  int           lo_cnt    = 1000;
  int           last_hi   = 0;
  int           valid_cnt = 0;
  int           fall [N]  = '{5, 7, 9};
  logic [N-1:0] stuck_hi  = '0;
  logic [N-1:0] never_hi  = '0;
  bit           glitch_en = 1'b0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] chan(input int i);
    return readings[i*CW +: CW];
  endfunction

  // One clock: sample outputs on the falling edge, then drive the pads.
  task automatic tick();
    @(negedge clock);
    if (sensors_out) begin
      hi_cnt++;
      lo_cnt = 0;
    end else begin
      if (hi_cnt != 0) last_hi = hi_cnt;
      hi_cnt = 0;
      if (lo_cnt < 1000) lo_cnt++;
    end
    if (readings_valid) valid_cnt++;
    for (int i = 0; i < N; i++) begin
      if (hi_cnt > 0)
        sensors_in[i] = !never_hi[i] && !(glitch_en && i == 0 && hi_cnt == 4);
      else
        sensors_in[i] = stuck_hi[i] || (lo_cnt < fall[i] - 1);
    end
  endtask

  task automatic wait_rise(input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (hi_cnt == 1) begin
        ok = 1'b1;
        break;
      end
    end
    check_value({tag, "_scan_start"}, 64'(ok), 64'd1);
  endtask

  task automatic run_scan(input string tag);
    valid_cnt = 0;
    last_hi   = 0;
    wait_rise(tag);
    repeat (50) tick();
  endtask

  task automatic check_readings(input string tag, input int e0, input int e1, input int e2);
    check_value({tag, "_r0"}, 64'(chan(0)), 64'(e0));
    check_value({tag, "_r1"}, 64'(chan(1)), 64'(e1));
    check_value({tag, "_r2"}, 64'(chan(2)), 64'(e2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap;
    bit seen;

    repeat (3) tick();
    check_value("rst_drive", 64'(sensors_out), 64'd0);
    check_readings("rst", 0, 0, 0);
    check_value("rst_valid", 64'(readings_valid), 64'd0);
    check_value("rst_dt", 64'(discharge_timeout), 64'd0);
    check_value("rst_cf", 64'(charge_fault), 64'd0);
    reset = 1'b0;

    // Nominal: 4 all-high samples from cycle 2 end charge after 6 drive cycles.
    fall = '{5, 7, 9};
    run_scan("nom");
    check_value("nom_charge_len", 64'(last_hi), 64'd6);
    check_value("nom_valid", 64'(valid_cnt), 64'd1);
    check_readings("nom", 5, 7, 9);
    check_value("nom_dt", 64'(discharge_timeout), 64'd0);
    check_value("nom_cf", 64'(charge_fault), 64'd0);
`ifdef CAP_SENSOR_TOUCH_EN
    check_value("nom_touched", 64'(touched), 64'd0);
`endif

    // Glitch: one low sample after 3 highs; charged exactly at the timeout cycle.
    glitch_en = 1'b1;
    run_scan("glitch");
    glitch_en = 1'b0;
    check_value("glitch_charge_len", 64'(last_hi), 64'd10);
    check_value("glitch_valid", 64'(valid_cnt), 64'd1);
    check_readings("glitch", 5, 7, 9);
    check_value("glitch_dt", 64'(discharge_timeout), 64'd0);

    // Charge fault: channel 1 never charges.
    never_hi = 3'b010;
    run_scan("cfault");
    never_hi = '0;
    check_value("cfault_charge_len", 64'(last_hi), 64'd10);
    check_value("cfault_cf", 64'(charge_fault), 64'd1);
    check_value("cfault_valid", 64'(valid_cnt), 64'd0);
    check_readings("cfault", 5, 7, 9);

    // Discharge timeout: channel 2 stuck high saturates at 20.
    stuck_hi = 3'b100;
    run_scan("dto");
    stuck_hi = '0;
    check_value("dto_valid", 64'(valid_cnt), 64'd1);
    check_readings("dto", 5, 7, 20);
    check_value("dto_dt", 64'(discharge_timeout), 64'd4);
    check_value("dto_cf", 64'(charge_fault), 64'd0);
`ifdef CAP_SENSOR_TOUCH_EN
    check_value("dto_touched", 64'(touched), 64'd4);
`endif

    // Channel 1 slower: 10 > baseline 7 + threshold 2.
    fall = '{5, 10, 9};
    run_scan("touch");
    check_value("touch_valid", 64'(valid_cnt), 64'd1);
    check_readings("touch", 5, 10, 9);
    check_value("touch_dt", 64'(discharge_timeout), 64'd0);
`ifdef CAP_SENSOR_TOUCH_EN
    check_value("touch_touched", 64'(touched), 64'd2);
`endif

    // Reset in the middle of a discharge.
    fall = '{5, 7, 9};
    wait_rise("mid");
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!sensors_out) begin
        seen = 1'b1;
        break;
      end
    end
    check_value("mid_discharge_entry", 64'(seen), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    check_value("mid_rst_drive", 64'(sensors_out), 64'd0);
    check_value("mid_rst_valid", 64'(readings_valid), 64'd0);
    check_readings("mid_rst", 0, 0, 0);
    check_value("mid_rst_dt", 64'(discharge_timeout), 64'd0);
    reset = 1'b0;
    tick();
    check_value("mid_restart_drive", 64'(sensors_out), 64'd1);
    gap  = 0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      gap++;
      if (hi_cnt == 1) begin
        seen = 1'b1;
        break;
      end
    end
    check_value("mid_next_scan_seen", 64'(seen), 64'd1);
    check_value("mid_next_scan_gap", 64'(gap), 64'd64);
    check_readings("mid_after", 5, 7, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/capacitive_sensor_scanner.md
Name: capacitive_sensor_scanner

Overview:
Parametrised successor to the 9-channel capacitive sensor front end. Repeatedly charges N RC sensor pads through one shared drive pin and times each pad's discharge with a per-channel counter. Publishes a coherent snapshot of all counts with a valid strobe, plus charge and discharge fault flags. Sits between the pad I/O and the whack-a-mole hit-detection logic.

Parameters:
NUM_SENSORS, 9, number of sensor channels (1..32)
COUNT_WIDTH, 32, width of each discharge count
PERIOD_CYCLES, 100000, clocks from one scan start to the next (must exceed CHARGE_TIMEOUT + CHARGE_CYCLES + DISCHARGE_TIMEOUT + 4)
CHARGE_CYCLES, 20000, consecutive all-high clocks required before the pads count as charged
CHARGE_TIMEOUT, 40000, maximum clocks allowed to reach all-high
DISCHARGE_TIMEOUT, 30000, maximum discharge clocks per scan; counts saturate here

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
sensors_in  in  NUM_SENSORS  raw pad threshold inputs, asynchronous
sensors_out  out  1  shared charge drive, 1 = charging
readings  out  NUM_SENSORS*COUNT_WIDTH  latched counts; channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]
readings_valid  out  1  one-cycle pulse when readings update
discharge_timeout  out  NUM_SENSORS  per channel: 1 = channel hit DISCHARGE_TIMEOUT in the last scan
charge_fault  out  1  1 = last scan aborted because the pads never charged

Behaviour:
- One clock domain. Reset is synchronous and active-high. Every register updates on posedge clock.
- Each sensors_in bit passes through a 2-flop synchroniser. All logic below uses the synchronised value s[i], so input-to-logic latency is 2 cycles.
- Reset values: sensors_out=0, readings=0, readings_valid=0, discharge_timeout=0, charge_fault=0, state=IDLE, all counters=0.
- period_cnt is a free-running counter from 0 to PERIOD_CYCLES-1 that wraps to 0. Reset clears it. A scan starts when period_cnt==0 and state==IDLE.
- IDLE: sensors_out=0. On scan start, go to CHARGE; clear charge_cnt, timeout_cnt and all channel counters.
- CHARGE: sensors_out=1; timeout_cnt increments each cycle.
  - If &s is true, charge_cnt increments; otherwise charge_cnt resets to 0, because the all-high run must be consecutive.
  - When charge_cnt==CHARGE_CYCLES-1 and &s is true, go to DISCHARGE next cycle.
  - Else when timeout_cnt==CHARGE_TIMEOUT-1, go to IDLE, set charge_fault=1, leave readings unchanged and do not pulse valid.
- DISCHARGE: sensors_out=0; timeout_cnt restarts at 0 on entry.
  - For each channel, cnt[i] increments every cycle while s[i]==1 and the channel has not stopped.
  - A channel stops permanently for the scan on its first cycle with s[i]==0.
  - When all channels have stopped, or timeout_cnt==DISCHARGE_TIMEOUT-1, go to LATCH. Unstopped channels keep cnt = min(count, DISCHARGE_TIMEOUT) and get their timeout flag set.
- LATCH, one cycle: readings<=cnt, discharge_timeout<=flags, charge_fault<=0, readings_valid=1 for exactly this cycle. Then go to IDLE.
- Counts saturate at 2^COUNT_WIDTH-1 and never wrap.
- readings hold their value between valid pulses. Consumers sample only on readings_valid.
- If reset asserts mid-scan, the next cycle is the reset state: drive released (sensors_out=0), no valid pulse, prior readings cleared to 0.
- A scan-start tick that arrives while not IDLE is ignored; it cannot occur when the PERIOD_CYCLES constraint is met.

Optional Feature:
CAP_SENSOR_TOUCH_EN:
- When defined, add input touch_threshold [COUNT_WIDTH-1:0] and output touched [NUM_SENSORS-1:0].
- The first successful LATCH after reset stores per-channel baselines.
- On each later LATCH, touched[i] <= (readings[i] > baseline[i] + touch_threshold), with the sum saturating.
- touched updates in the same cycle as readings_valid. It stays 0 until the baseline has been captured.
- When the macro is undefined, neither port exists and no baseline registers are built.

Test Plan:
All scenarios use NUM_SENSORS=3, CHARGE_CYCLES=4, CHARGE_TIMEOUT=10, DISCHARGE_TIMEOUT=20, PERIOD_CYCLES=64.
- Nominal scan: pads go high 3 cycles after sensors_out rises; pads fall 5, 7 and 9 cycles after it drops -> readings = {9,7,5} (channel2..0, counted on synchronised inputs), one valid pulse, all flags 0.
- Charge glitch: &sensors_in drops for 1 cycle after 3 high cycles -> charge_cnt restarts; DISCHARGE entry is delayed by exactly 4 further all-high cycles.
- Charge fault: sensors_in[1] held at 0 -> sensors_out high for 10 cycles, then charge_fault=1, no valid pulse, readings unchanged.
- Discharge timeout: sensors_in[2] stuck at 1 -> channel 2 reading=20, discharge_timeout=3'b100, other channels correct, valid pulses.
- Reset mid-DISCHARGE -> next cycle sensors_out=0, readings=0, no valid pulse; the next scan starts 64 cycles after reset deasserts.
- CAP_SENSOR_TOUCH_EN with touch_threshold=2: baseline {9,7,5}, next scan {9,10,5} -> touched=3'b010.
